// File: rtl/exp_pkg.sv
// Types and constants shared between range reduction and the exp series stage.
package exp_pkg;

  localparam int unsigned FRAC_BITS = 16;
  localparam int unsigned LN2_Q     = 45426;  // ln2 in Q0.16
  localparam int unsigned INV_LN2_Q = 94548;  // 1/ln2 in Q1.16

  typedef logic signed [23:0] fixed_t;   // Q8.16
  typedef logic signed [8:0]  exp_k_t;   // integer exponent k
  typedef logic signed [41:0] prod_t;    // x * INV_LN2_Q, Q.32

  typedef struct packed {
    fixed_t x;
    prod_t  p;
  } s1_t;

  typedef struct packed {
    exp_k_t k;
    fixed_t r;
  } s2_t;

endpackage

// File: rtl/exp_range_reduce_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when being drained.
module pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid;
  logic [WIDTH-1:0] data;

  assign in_ready  = !valid || out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  // Slice register: capture new data whenever the slot is free or emptying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (in_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/exp_range_reduce.sv
// Range reduction for exp(X): X = k*ln2 + r, k = round(X/ln2), two-stage pipeline.
module exp_range_reduce #(
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned INT_BITS  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [INT_BITS+FRAC_BITS-1:0] in_x,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [8:0]                   out_k,
  output logic signed [INT_BITS+FRAC_BITS-1:0] out_r
);

  import exp_pkg::*;

  s1_t  s1_d;
  s1_t  s1_q;
  s2_t  s2_d;
  s2_t  s2_q;
  logic s1_valid;
  logic s2_ready;

  // Stage 1 input: full-width product x * (1/ln2), kept in Q.32.
  always_comb begin
    s1_d   = '0;
    s1_d.x = in_x;
    s1_d.p = prod_t'(in_x) * prod_t'(INV_LN2_Q);
  end

  // Stage 2 input: round-half-up k, then remainder r = x - k*ln2 at full width.
  always_comb begin
    s2_d   = '0;
    s2_d.k = exp_k_t'((s1_q.p + (prod_t'(1) <<< 31)) >>> 32);
    s2_d.r = fixed_t'(prod_t'(s1_q.x) - prod_t'(s2_d.k) * prod_t'(LN2_Q));
  end

  pipe_stage #(.WIDTH($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  pipe_stage #(.WIDTH($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_k = s2_q.k;
  assign out_r = s2_q.r;

endmodule

// File: tb/tb_exp_range_reduce.sv
// Self-checking bench for exp_range_reduce: directed vectors plus a scoreboard model.
module tb_exp_range_reduce;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [23:0] in_x = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [8:0]  out_k;
  logic signed [23:0] out_r;

  int checks = 0;
  int errors = 0;

  longint exp_k_q[$];
  longint exp_r_q[$];

  always #5 clk = ~clk;

  exp_range_reduce #(.FRAC_BITS(16), .INT_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_k     (out_k),
    .out_r     (out_r)
  );

  // k = nearest integer to X/ln2 (ties upward), with 1/ln2 and ln2 as 16-bit fractions.
  function automatic void model(input longint x, output longint k, output longint r);
    real q;
    q = $floor((real'(x) * 94548.0) / 4294967296.0 + 0.5);
    k = longint'(q);
    r = x - k * 45426;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Scoreboard: record accepted inputs, check every output transfer and every stall hold.
  logic               stall = 1'b0;
  logic signed [8:0]  hold_k;
  logic signed [23:0] hold_r;
  always @(negedge clk) begin
    longint ek, er;
    if (!rst_n) begin
      exp_k_q.delete();
      exp_r_q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_k", longint'(out_k), longint'(hold_k));
        chk("stall_r", longint'(out_r), longint'(hold_r));
      end
      if (out_valid && out_ready) begin
        if (exp_k_q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          ek = exp_k_q.pop_front();
          er = exp_r_q.pop_front();
          chk("model_k", longint'(out_k), ek);
          chk("model_r", longint'(out_r), er);
        end
      end
      if (in_valid && in_ready) begin
        model(longint'(in_x), ek, er);
        exp_k_q.push_back(ek);
        exp_r_q.push_back(er);
      end
      stall  = out_valid && !out_ready;
      hold_k = out_k;
      hold_r = out_r;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One isolated transfer with latency and literal result checks.
  task automatic single(input logic signed [23:0] x, input longint ek, input longint er);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_accept", longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_lat1_valid", longint'(out_valid), 0);
    @(negedge clk);
    chk("single_lat2_valid", longint'(out_valid), 1);
    chk("single_k", longint'(out_k), ek);
    chk("single_r", longint'(out_r), er);
  endtask

  logic signed [23:0] vec[8];
  logic signed [23:0] bp[3];
  logic signed [23:0] mix[6];

  initial begin
    longint k, r;
    int idx;
    int nout;

    // Pin the model against hand-computed values.
    model(65536, k, r);    chk("pin_k_one", k, 1);     chk("pin_r_one", r, 20110);
    model(-65536, k, r);   chk("pin_k_mone", k, -1);   chk("pin_r_mone", r, -20110);
    model(22713, k, r);    chk("pin_k_half", k, 0);    chk("pin_r_half", r, 22713);
    model(8388607, k, r);  chk("pin_k_max", k, 185);   chk("pin_r_max", r, -15203);
    model(-8388608, k, r); chk("pin_k_min", k, -185);  chk("pin_r_min", r, 15202);

    // Reset state.
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_k", longint'(out_k), 0);
    chk("rst_out_r", longint'(out_r), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);

    // Directed single values, including rounding boundaries and range extremes.
    single(24'sd0, 0, 0);
    single(24'sd65536, 1, 20110);
    single(-24'sd65536, -1, -20110);
    single(24'sd22713, 0, 22713);
    single(24'sd22714, 1, -22712);
    single(24'sd8388607, 185, -15203);
    single(-24'sd8388608, -185, 15202);

    // Back-to-back: eight inputs, outputs on consecutive cycles.
    for (int i = 0; i < 8; i++) vec[i] = 24'(i * 300000 - 1000000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (i < 8);
      in_x      = (i < 8) ? vec[i] : '0;
      @(negedge clk);
      if (i < 8) chk("b2b_in_ready", longint'(in_ready), 1);
      if (i >= 2) chk("b2b_out_valid", longint'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Backpressure: five stalled cycles with three inputs offered.
    bp[0] = 24'sd65536; bp[1] = -24'sd65536; bp[2] = 24'sd131072;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (idx < 3);
      in_x      = bp[idx < 3 ? idx : 2];
      @(negedge clk);
      chk("bp_in_ready", longint'(in_ready), (i < 2) ? 1 : 0);
      if (in_valid && in_ready) idx++;
      if (i >= 2) begin
        chk("bp_out_valid", longint'(out_valid), 1);
        chk("bp_hold_k", longint'(out_k), 1);
        chk("bp_hold_r", longint'(out_r), 20110);
      end
    end
    chk("bp_accepted_stalled", idx, 2);
    nout = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (idx < 3);
      in_x      = bp[idx < 3 ? idx : 2];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) nout++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted_total", idx, 3);
    chk("bp_outputs", nout, 3);

    // Reset with both stages full: outputs clear at once, nothing stale afterwards.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = (i < 2);
      in_x      = 24'(1000 + i * 70000);
      @(negedge clk);
    end
    chk("rst_pre_full", longint'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    chk("rst_mid_out_k", longint'(out_k), 0);
    chk("rst_mid_out_r", longint'(out_r), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_stale", longint'(out_valid), 0);
    end

    // Mixed stream under intermittent backpressure; scoreboard checks order and values.
    mix[0] = 24'sd1; mix[1] = -24'sd1; mix[2] = 24'sd45426;
    mix[3] = -24'sd22713; mix[4] = 24'sd3000000; mix[5] = -24'sd5000000;
    idx = 0;
    for (int i = 0; i < 40 && idx < 6; i++) begin
      @(posedge clk); #1;
      out_ready = (i % 3 != 0);
      in_valid  = 1'b1;
      in_x      = mix[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mix_accepted", idx, 6);
    for (int i = 0; i < 20 && exp_k_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", exp_k_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
